// File: rtl/e203_exu_decq_pkg.sv
// Shared decode constants, MUL/DIV class encoding and the fusion-history record.
package e203_exu_decq_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_f3_e;

  // Fields of the most recently popped instruction; hv marks a usable MUL/DIV
  typedef struct packed {
    logic       hv;
    muldiv_f3_e funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } hist_t;

  function automatic logic is_muldiv(input logic [31:0] instr);
    return (instr[1:0] == 2'b11) && (instr[6:0] == OPCODE_OP) &&
           (instr[31:25] == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/e203_exu_decq_if.sv
// Upstream (IR stage) and downstream (decoder) handshake bundle of the decode queue.
interface e203_exu_decq_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
);
  logic               i_valid;
  logic               i_ready;
  logic [INSTR_W-1:0] i_instr;
  logic [PC_W-1:0]    i_pc;
  logic               i_prdt_taken;
  logic               i_misalgn;
  logic               i_buserr;
  logic               o_valid;
  logic               o_ready;
  logic [INSTR_W-1:0] o_instr;
  logic [PC_W-1:0]    o_pc;
  logic               o_prdt_taken;
  logic               o_misalgn;
  logic               o_buserr;
  logic               o_rv32;
  logic               o_muldiv_b2b;

  // Queue side
  modport slave (
    input  i_valid, i_instr, i_pc, i_prdt_taken, i_misalgn, i_buserr, o_ready,
    output i_ready, o_valid, o_instr, o_pc, o_prdt_taken, o_misalgn, o_buserr,
           o_rv32, o_muldiv_b2b
  );

  // Producer/consumer side
  modport master (
    output i_valid, i_instr, i_pc, i_prdt_taken, i_misalgn, i_buserr, o_ready,
    input  i_ready, o_valid, o_instr, o_pc, o_prdt_taken, o_misalgn, o_buserr,
           o_rv32, o_muldiv_b2b
  );
endinterface

// File: rtl/e203_exu_decq_b2b.sv
// Head-entry MUL/DIV pre-decode: fusion flag against history and next history value.
module e203_exu_decq_b2b
  import e203_exu_decq_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        head_valid,
  input  logic        head_misalgn,
  input  logic        head_buserr,
  input  hist_t       hist,
  input  logic        dbg_mode,
  output logic        b2b,
  output hist_t       hist_next
);

  logic       head_md;
  muldiv_f3_e head_f3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       pair_ok;

  // Field extraction of the head instruction
  always_comb begin
    head_md = is_muldiv(instr);
    head_f3 = muldiv_f3_e'(instr[14:12]);
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    rd      = instr[11:7];
  end

  // Legal (previous, head) class pairs: high-half mul -> MUL, DIV -> REM, DIVU -> REMU
  always_comb begin
    pair_ok = 1'b0;
    case (hist.funct3)
      F3_MULH, F3_MULHSU, F3_MULHU: pair_ok = (head_f3 == F3_MUL);
      F3_DIV:                       pair_ok = (head_f3 == F3_REM);
      F3_DIVU:                      pair_ok = (head_f3 == F3_REMU);
      default:                      pair_ok = 1'b0;
    endcase
  end

  // Fusion flag; the previous result must not overwrite either shared source
  always_comb begin
    b2b = head_valid && !dbg_mode && hist.hv && head_md &&
          (rs1 == hist.rs1) && (rs2 == hist.rs2) &&
          (hist.rd != hist.rs1) && (hist.rd != hist.rs2) && pair_ok;
  end

  // History candidate; a faulting or non-MUL/DIV pop breaks any pairing
  always_comb begin
    hist_next.hv     = head_md && !head_misalgn && !head_buserr;
    hist_next.funct3 = head_f3;
    hist_next.rs1    = rs1;
    hist_next.rs2    = rs2;
    hist_next.rd     = rd;
  end

endmodule

// File: rtl/e203_exu_decq.sv
// Decode-side instruction queue between the IFU IR stage and the EXU decoder.
module e203_exu_decq
  import e203_exu_decq_pkg::*;
#(
  parameter  int DEPTH   = 2,
  parameter  int INSTR_W = 32,
  parameter  int PC_W    = 32,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dbg_mode,
  e203_exu_decq_if.slave    bus,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [2:0]         flag_mem  [DEPTH];   // {prdt_taken, misalgn, buserr}

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [2:0]       head_flags;
  hist_t            hist_q;
  hist_t            hist_next;

  // Non-power-of-two depths wrap by explicit compare
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy status and handshake qualification; flush suppresses both transfers
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    push  = bus.i_valid && !full && !flush;
    pop   = !empty && bus.o_ready && !flush;
  end

  // Pointer, occupancy and history state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hist_q <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hist_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        hist_q <= hist_next;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage, written at the tail; intentionally not reset
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.i_instr;
      pc_mem[wr_ptr]    <= bus.i_pc;
      flag_mem[wr_ptr]  <= {bus.i_prdt_taken, bus.i_misalgn, bus.i_buserr};
    end
  end

  // Head presentation; i_ready comes from registered occupancy only
  always_comb begin
    head_flags       = flag_mem[rd_ptr];
    bus.i_ready      = !full;
    bus.o_valid      = !empty;
    bus.o_instr      = instr_mem[rd_ptr];
    bus.o_pc         = pc_mem[rd_ptr];
    bus.o_prdt_taken = head_flags[2];
    bus.o_misalgn    = head_flags[1];
    bus.o_buserr     = head_flags[0];
    bus.o_rv32       = (bus.o_instr[1:0] == 2'b11);
    o_count          = count;
  end

  e203_exu_decq_b2b u_b2b (
    .instr        (bus.o_instr[31:0]),
    .head_valid   (!empty),
    .head_misalgn (head_flags[1]),
    .head_buserr  (head_flags[0]),
    .hist         (hist_q),
    .dbg_mode     (dbg_mode),
    .b2b          (bus.o_muldiv_b2b),
    .hist_next    (hist_next)
  );

endmodule

// File: tb/tb_e203_exu_decq.sv
// Bench for e203_exu_decq: DEPTH=2 and DEPTH=3 instances against a queue-based model.
module tb_e203_exu_decq;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pt;
    logic        mis;
    logic        be;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       dbg_mode = 1'b0;
  logic [1:0] cnt2;
  logic [1:0] cnt3;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: FIFO contents and last popped instruction per instance
  entry_t      q2[$];
  entry_t      q3[$];
  bit          h2v, h3v;
  logic [31:0] h2i, h3i;

  e203_exu_decq_if #(.INSTR_W(32), .PC_W(32)) if2 ();
  e203_exu_decq_if #(.INSTR_W(32), .PC_W(32)) if3 ();

  e203_exu_decq #(.DEPTH(2), .INSTR_W(32), .PC_W(32)) d2 (
    .clk(clk), .rst(rst), .flush(flush), .dbg_mode(dbg_mode), .bus(if2), .o_count(cnt2));
  e203_exu_decq #(.DEPTH(3), .INSTR_W(32), .PC_W(32)) d3 (
    .clk(clk), .rst(rst), .flush(flush), .dbg_mode(dbg_mode), .bus(if3), .o_count(cnt3));

  always #5 clk = ~clk;

  localparam logic [31:0] ADD   = 32'h00A50533;
  localparam logic [31:0] MULH  = 32'h022092B3;
  localparam logic [31:0] MUL   = 32'h02208333;
  localparam logic [31:0] MULH1 = 32'h022090B3;
  localparam logic [31:0] DIVU  = 32'h0220D2B3;
  localparam logic [31:0] REM   = 32'h0220E333;
  localparam logic [31:0] REMU  = 32'h0220F333;

  function automatic bit is_md(input logic [31:0] w);
    return (w[6:0] == 7'h33) && (w[31:25] == 7'h01);
  endfunction

  // Fusion rule applied to a previous/current instruction word pair
  function automatic bit exp_b2b(input bit hv, input logic [31:0] h, input logic [31:0] c,
                                 input logic dbg);
    int hf3, cf3;
    if (dbg || !hv || !is_md(c)) return 0;
    if (h[19:15] != c[19:15] || h[24:20] != c[24:20]) return 0;
    if (h[11:7] == h[19:15] || h[11:7] == h[24:20]) return 0;
    hf3 = int'(h[14:12]);
    cf3 = int'(c[14:12]);
    return (hf3 >= 1 && hf3 <= 3 && cf3 == 0) || (hf3 == 4 && cf3 == 6) ||
           (hf3 == 5 && cf3 == 7);
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    rs1 = 5'($urandom_range(1, 2));
    rs2 = 5'($urandom_range(1, 2));
    rd  = 5'($urandom_range(0, 4));
    f3  = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 4))
      0:       return $urandom();
      1:       return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      default: return {7'h01, rs2, rs1, f3, rd, 7'h33};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q2.delete(); q3.delete();
    h2v = 0; h3v = 0;
  endtask

  // Apply the handshakes seen at this edge to the reference queues
  task automatic model_edge();
    entry_t e;
    bit pu, po;
    if (flush) begin
      model_reset();
      return;
    end
    pu = if2.i_valid && (q2.size() < 2);
    po = (q2.size() > 0) && if2.o_ready;
    if (po) begin e = q2.pop_front(); h2i = e.instr; h2v = is_md(e.instr) && !e.mis && !e.be; end
    if (pu) q2.push_back({if2.i_instr, if2.i_pc, if2.i_prdt_taken, if2.i_misalgn, if2.i_buserr});
    pu = if3.i_valid && (q3.size() < 3);
    po = (q3.size() > 0) && if3.o_ready;
    if (po) begin e = q3.pop_front(); h3i = e.instr; h3v = is_md(e.instr) && !e.mis && !e.be; end
    if (pu) q3.push_back({if3.i_instr, if3.i_pc, if3.i_prdt_taken, if3.i_misalgn, if3.i_buserr});
  endtask

  task automatic check_all();
    chk("d2 i_ready", if2.i_ready, q2.size() != 2);
    chk("d2 o_valid", if2.o_valid, q2.size() != 0);
    chk("d2 o_count", cnt2, q2.size());
    chk("d2 b2b", if2.o_muldiv_b2b,
        (q2.size() != 0) ? exp_b2b(h2v, h2i, q2[0].instr, dbg_mode) : 1'b0);
    if (q2.size() != 0) begin
      chk("d2 o_instr", if2.o_instr, q2[0].instr);
      chk("d2 o_pc", if2.o_pc, q2[0].pc);
      chk("d2 flags", {if2.o_prdt_taken, if2.o_misalgn, if2.o_buserr},
          {q2[0].pt, q2[0].mis, q2[0].be});
      chk("d2 o_rv32", if2.o_rv32, q2[0].instr[1:0] == 2'b11);
    end
    chk("d3 i_ready", if3.i_ready, q3.size() != 3);
    chk("d3 o_valid", if3.o_valid, q3.size() != 0);
    chk("d3 o_count", cnt3, q3.size());
    chk("d3 b2b", if3.o_muldiv_b2b,
        (q3.size() != 0) ? exp_b2b(h3v, h3i, q3[0].instr, dbg_mode) : 1'b0);
    if (q3.size() != 0) begin
      chk("d3 o_instr", if3.o_instr, q3[0].instr);
      chk("d3 o_pc", if3.o_pc, q3[0].pc);
      chk("d3 flags", {if3.o_prdt_taken, if3.o_misalgn, if3.o_buserr},
          {q3[0].pt, q3[0].mis, q3[0].be});
      chk("d3 o_rv32", if3.o_rv32, q3[0].instr[1:0] == 2'b11);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic put2(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if2.i_valid = v; if2.i_instr = ins; if2.i_pc = pc;
    if2.i_prdt_taken = 1'b0; if2.i_misalgn = 1'b0; if2.i_buserr = 1'b0;
  endtask

  // Queue two instructions, then pop them; check the fusion flag on each head
  task automatic pair(input logic [31:0] a, input logic [31:0] b, input logic dbg,
                      input logic expb, input string tag);
    dbg_mode = dbg;
    if2.o_ready = 1'b0;
    put2(1'b1, a, 32'h1000); cycle();
    put2(1'b1, b, 32'h1004); cycle();
    put2(1'b0, 32'h0, 32'h0);
    chk({tag, " first"}, if2.o_muldiv_b2b, 1'b0);
    if2.o_ready = 1'b1; cycle();
    chk({tag, " second"}, if2.o_muldiv_b2b, expb);
    cycle();
    if2.o_ready = 1'b0;
    dbg_mode = 1'b0;
  endtask

  initial begin
    put2(1'b0, 32'h0, 32'h0);
    if2.o_ready = 1'b0;
    if3.i_valid = 1'b0; if3.i_instr = '0; if3.i_pc = '0;
    if3.i_prdt_taken = 1'b0; if3.i_misalgn = 1'b0; if3.i_buserr = 1'b0;
    if3.o_ready = 1'b0;
    model_reset();
    h2i = '0; h3i = '0;

    // Reset state
    #12;
    check_all();
    rst = 1'b0;

    // First push visible one cycle later
    put2(1'b1, ADD, 32'h80000000);
    cycle();
    put2(1'b0, 32'h0, 32'h0);
    chk("first o_valid", if2.o_valid, 1'b1);
    chk("first o_pc", if2.o_pc, 32'h80000000);
    chk("first o_rv32", if2.o_rv32, 1'b1);
    chk("first o_count", cnt2, 2'd1);
    if2.o_ready = 1'b1; cycle(); if2.o_ready = 1'b0;

    // Fill with o_ready low: third push held until space frees
    for (int k = 0; k < 3; k++) begin
      put2(1'b1, ADD, 32'h100 + 32'(4 * k));
      cycle();
    end
    chk("full i_ready", if2.i_ready, 1'b0);
    chk("full count", cnt2, 2'd2);
    if2.o_ready = 1'b1;
    while (if2.i_ready == 1'b0 || q2.size() == 2) begin
      cycle();
      if (q2.size() < 2 && if2.o_pc != 32'h100) break;
    end
    put2(1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) cycle();
    if2.o_ready = 1'b0;
    chk("drained", if2.o_valid, 1'b0);

    // Fusion pairs
    pair(MULH, MUL, 1'b0, 1'b1, "mulh-mul");
    pair(MULH1, MUL, 1'b0, 1'b0, "rd-clobber");
    pair(MULH, MUL, 1'b1, 1'b0, "dbg");
    pair(DIVU, REM, 1'b0, 1'b0, "divu-rem");
    pair(DIVU, REMU, 1'b0, 1'b1, "divu-remu");

    // Streaming MULH, ADD, MUL: ADD breaks the pairing
    if2.o_ready = 1'b1;
    put2(1'b1, MULH, 32'h2000); cycle();
    put2(1'b1, ADD, 32'h2004); cycle();
    put2(1'b1, MUL, 32'h2008); cycle();
    chk("intervening b2b", if2.o_muldiv_b2b, 1'b0);
    put2(1'b0, 32'h0, 32'h0); cycle();

    // Flush with push and pop pending drops everything, including history
    if2.o_ready = 1'b0;
    put2(1'b1, MULH, 32'h3000); cycle();
    put2(1'b0, 32'h0, 32'h0); if2.o_ready = 1'b1; cycle();
    if2.o_ready = 1'b0;
    put2(1'b1, ADD, 32'h3004); cycle();
    put2(1'b1, ADD, 32'h3008); cycle();
    flush = 1'b1; put2(1'b1, MUL, 32'h300C); if2.o_ready = 1'b1;
    #1;
    chk("flush-cycle i_ready", if2.i_ready, 1'b0);
    cycle();
    flush = 1'b0; put2(1'b0, 32'h0, 32'h0); if2.o_ready = 1'b0;
    chk("flush o_valid", if2.o_valid, 1'b0);
    chk("flush o_count", cnt2, 2'd0);
    put2(1'b1, MUL, 32'h3010); cycle();
    put2(1'b0, 32'h0, 32'h0);
    chk("post-flush b2b", if2.o_muldiv_b2b, 1'b0);
    if2.o_ready = 1'b1; cycle();

    // Asynchronous reset mid-burst, away from the clock edge
    for (int k = 0; k < 3; k++) begin
      put2(1'b1, rnd_instr(), 32'h4000 + 32'(4 * k));
      if2.o_ready = (k != 0);
      cycle();
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async o_count", cnt2, 2'd0);
    chk("async i_ready", if2.i_ready, 1'b1);
    put2(1'b0, 32'h0, 32'h0); if2.o_ready = 1'b0;
    #2;
    rst = 1'b0;

    // DEPTH=3 continuous push+pop through several wraps
    if3.o_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if3.i_valid = (k < 7);
      if3.i_instr = rnd_instr();
      if3.i_pc = 32'h5000 + 32'(4 * k);
      cycle();
      if (k < 7) begin
        chk("wrap o_pc", if3.o_pc, 32'h5000 + 32'(4 * k));
        chk("wrap count", cnt3, 2'd1);
      end
    end
    if3.i_valid = 1'b0;

    // Randomised traffic on both instances
    for (int k = 0; k < 400; k++) begin
      put2($urandom_range(0, 3) != 0, rnd_instr(), $urandom());
      if2.i_prdt_taken = $urandom_range(0, 3) == 0;
      if2.i_misalgn = $urandom_range(0, 7) == 0;
      if2.i_buserr = $urandom_range(0, 7) == 0;
      if2.o_ready = $urandom_range(0, 2) != 0;
      if3.i_valid = $urandom_range(0, 3) != 0;
      if3.i_instr = rnd_instr();
      if3.i_pc = $urandom();
      if3.i_prdt_taken = $urandom_range(0, 3) == 0;
      if3.i_misalgn = $urandom_range(0, 7) == 0;
      if3.i_buserr = $urandom_range(0, 7) == 0;
      if3.o_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 40) == 0;
      dbg_mode = $urandom_range(0, 15) == 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
